// File: rtl/jtkcpu_idx_pkg.sv
// Shared definitions for the indexed-addressing fetch sequencer and decoder.
package jtkcpu_idx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_POST = 3'd1,
      ST_EXT1 = 3'd2,
      ST_EXT2 = 3'd3,
      ST_IND1 = 3'd4,
      ST_IND2 = 3'd5,
      ST_DONE = 3'd6
   } idx_state_t;

   // Postbyte low-nibble mode codes (postbyte[7] = 0)
   localparam logic [3:0] MODE_INC1  = 4'b0000;
   localparam logic [3:0] MODE_INC2  = 4'b0001;
   localparam logic [3:0] MODE_DEC1  = 4'b0010;
   localparam logic [3:0] MODE_DEC2  = 4'b0011;
   localparam logic [3:0] MODE_ZERO  = 4'b0100;
   localparam logic [3:0] MODE_ACCB  = 4'b0101;
   localparam logic [3:0] MODE_ACCA  = 4'b0110;
   localparam logic [3:0] MODE_OFF8  = 4'b1000;
   localparam logic [3:0] MODE_OFF16 = 4'b1001;
   localparam logic [3:0] MODE_ACCD  = 4'b1011;
   localparam logic [3:0] MODE_PC8   = 4'b1100;
   localparam logic [3:0] MODE_PC16  = 4'b1101;
   localparam logic [3:0] MODE_EXTND = 4'b1111;

   // Number of extension bytes that follow the postbyte
   function automatic logic [1:0] ext_count(input logic [7:0] pb);
      logic [1:0] n;
      n = 2'd0;
      if (!pb[7]) begin
         case (pb[3:0])
            MODE_OFF8, MODE_PC8:               n = 2'd1;
            MODE_OFF16, MODE_PC16, MODE_EXTND: n = 2'd2;
            default:                           n = 2'd0;
         endcase
      end
      return n;
   endfunction

   // 5-bit offset forms are never indirect
   function automatic logic is_indirect(input logic [7:0] pb);
      return !pb[7] && pb[4];
   endfunction

endpackage

// File: rtl/jtkcpu_idx_off.sv
// Combinational postbyte decode: offset value, index usage, extension count, indirect flag.
module jtkcpu_idx_off
   import jtkcpu_idx_pkg::*;
(
   input  logic [7:0]  pb,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [15:0] ext,
   output logic [15:0] offset,
   output logic        use_idx,
   output logic [1:0]  ext_cnt,
   output logic        indirect
);

   // Offset selection; extended mode replaces the index register entirely
   always_comb begin
      offset   = 16'h0000;
      use_idx  = 1'b1;
      ext_cnt  = ext_count(pb);
      indirect = is_indirect(pb);
      if (pb[7]) begin
         offset = {{11{pb[4]}}, pb[4:0]};
      end else begin
         case (pb[3:0])
            MODE_INC1:           offset = 16'h0001;
            MODE_INC2:           offset = 16'h0002;
            MODE_DEC1:           offset = 16'hFFFF;
            MODE_DEC2:           offset = 16'hFFFE;
            MODE_ZERO:           offset = 16'h0000;
            MODE_ACCB:           offset = {{8{b[7]}}, b};
            MODE_ACCA:           offset = {{8{a[7]}}, a};
            MODE_OFF8, MODE_PC8: offset = {{8{ext[7]}}, ext[7:0]};
            MODE_OFF16, MODE_PC16: offset = ext;
            MODE_ACCD:           offset = {a, b};
            MODE_EXTND: begin
               offset  = ext;
               use_idx = 1'b0;
            end
            default:             offset = 16'h0000;
         endcase
      end
   end

endmodule

// File: rtl/jtkcpu_idx_fetch.sv
// Indexed-addressing bus sequencer: postbyte, extension bytes, EA, optional indirect read.
//
// state | meaning
// IDLE  | waiting for start
// POST  | reading postbyte at pc
// EXT1  | reading first extension byte
// EXT2  | reading second extension byte (low byte of 16-bit ext)
// IND1  | reading indirect high byte at ea
// IND2  | reading indirect low byte at ea+1
// DONE  | result valid, done pulse
module jtkcpu_idx_fetch
   import jtkcpu_idx_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        cen,
   input  logic        start,
   input  logic [15:0] pc,
   input  logic [15:0] idx_reg,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [7:0]  bus_din,
   input  logic        bus_wait,
   output logic [15:0] bus_addr,
   output logic        bus_rd,
   output logic [7:0]  postbyte,
   output logic [15:0] ea,
   output logic [15:0] pc_nxt,
   output logic        busy,
   output logic        done
);

   idx_state_t  state, state_nxt;
   logic [7:0]  ext_hi;
   logic [7:0]  ind_hi;
   logic [7:0]  pb_src;
   logic [15:0] ext_src;
   logic [15:0] offset;
   logic        use_idx;
   logic [1:0]  dec_cnt;
   logic        dec_ind;
   logic [15:0] ea_calc;
   logic        step;

   assign step = cen && !bus_wait;

   // In POST the postbyte is still on the bus; later steps use the latched copy
   assign pb_src  = (state == ST_POST) ? bus_din : postbyte;
   assign ext_src = (state == ST_EXT2) ? {ext_hi, bus_din} : {8'h00, bus_din};
   assign ea_calc = (use_idx ? idx_reg : 16'h0000) + offset;

   jtkcpu_idx_off u_off (
      .pb       (pb_src),
      .a        (a),
      .b        (b),
      .ext      (ext_src),
      .offset   (offset),
      .use_idx  (use_idx),
      .ext_cnt  (dec_cnt),
      .indirect (dec_ind)
   );

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and status outputs
   always_comb begin
      state_nxt = state;
      bus_rd    = 1'b0;
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      case (state)
         ST_IDLE: if (cen && start) state_nxt = ST_POST;
         ST_POST: begin
            bus_rd = 1'b1;
            if (step) begin
               if (dec_cnt != 2'd0) state_nxt = ST_EXT1;
               else if (dec_ind)    state_nxt = ST_IND1;
               else                 state_nxt = ST_DONE;
            end
         end
         ST_EXT1: begin
            bus_rd = 1'b1;
            if (step) begin
               if (dec_cnt == 2'd2) state_nxt = ST_EXT2;
               else if (dec_ind)    state_nxt = ST_IND1;
               else                 state_nxt = ST_DONE;
            end
         end
         ST_EXT2: begin
            bus_rd = 1'b1;
            if (step) state_nxt = dec_ind ? ST_IND1 : ST_DONE;
         end
         ST_IND1: begin
            bus_rd = 1'b1;
            if (step) state_nxt = ST_IND2;
         end
         ST_IND2: begin
            bus_rd = 1'b1;
            if (step) state_nxt = ST_DONE;
         end
         ST_DONE: if (cen) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Byte latches, bus address sequencing and result registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus_addr <= 16'h0000;
         postbyte <= 8'h00;
         ea       <= 16'h0000;
         pc_nxt   <= 16'h0000;
         ext_hi   <= 8'h00;
         ind_hi   <= 8'h00;
      end else if (cen) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  bus_addr <= pc;
                  pc_nxt   <= pc + 16'd1;
               end
            end
            ST_POST: begin
               if (!bus_wait) begin
                  postbyte <= bus_din;
                  pc_nxt   <= bus_addr + 16'd1 + {14'd0, dec_cnt};
                  if (dec_cnt != 2'd0) begin
                     bus_addr <= bus_addr + 16'd1;
                  end else begin
                     ea <= ea_calc;
                     if (dec_ind) bus_addr <= ea_calc;
                  end
               end
            end
            ST_EXT1: begin
               if (!bus_wait) begin
                  if (dec_cnt == 2'd2) begin
                     ext_hi   <= bus_din;
                     bus_addr <= bus_addr + 16'd1;
                  end else begin
                     ea <= ea_calc;
                     if (dec_ind) bus_addr <= ea_calc;
                  end
               end
            end
            ST_EXT2: begin
               if (!bus_wait) begin
                  ea <= ea_calc;
                  if (dec_ind) bus_addr <= ea_calc;
               end
            end
            ST_IND1: begin
               if (!bus_wait) begin
                  ind_hi   <= bus_din;
                  bus_addr <= bus_addr + 16'd1;
               end
            end
            ST_IND2: begin
               if (!bus_wait) ea <= {ind_hi, bus_din};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jtkcpu_idx_fetch.sv
// Self-checking bench for jtkcpu_idx_fetch with a byte-memory model and a spec-level EA model.
module tb_jtkcpu_idx_fetch;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cen;
   logic        start;
   logic [15:0] pc;
   logic [15:0] idx_reg;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [7:0]  bus_din;
   logic        bus_wait;
   logic [15:0] bus_addr;
   logic        bus_rd;
   logic [7:0]  postbyte;
   logic [15:0] ea;
   logic [15:0] pc_nxt;
   logic        busy;
   logic        done;

   logic [7:0]  mem [0:65535];

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] exp_ea;
   logic [15:0] exp_pcn;
   int          exp_lat;
   logic [15:0] exp_rd [$];
   logic [15:0] got_rd [$];

   always #5 clk = ~clk;

   assign bus_din = mem[bus_addr];

   jtkcpu_idx_fetch dut (
      .clk      (clk),
      .rstn     (rstn),
      .cen      (cen),
      .start    (start),
      .pc       (pc),
      .idx_reg  (idx_reg),
      .a        (a),
      .b        (b),
      .bus_din  (bus_din),
      .bus_wait (bus_wait),
      .bus_addr (bus_addr),
      .bus_rd   (bus_rd),
      .postbyte (postbyte),
      .ea       (ea),
      .pc_nxt   (pc_nxt),
      .busy     (busy),
      .done     (done)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: what the sequence must read and produce, from the addressing-mode rules
   task automatic model_txn(input logic [15:0] p, input logic [15:0] x,
                            input logic [7:0] av, input logic [7:0] bv);
      logic [7:0]  pbv;
      logic [15:0] p1, p2, e, e1;
      logic [15:0] e16;
      int          n, off;
      logic        ind;
      exp_rd.delete();
      p1  = p + 16'd1;
      p2  = p + 16'd2;
      pbv = mem[p];
      exp_rd.push_back(p);
      n   = 0;
      ind = 1'b0;
      e16 = {mem[p1], mem[p2]};
      if (pbv[7]) begin
         off = int'(pbv[4:0]);
         if (off >= 16) off = off - 32;
         e = 16'(int'(x) + off);
      end else begin
         ind = pbv[4];
         case (pbv[3:0])
            4'd8, 4'd12:        n = 1;
            4'd9, 4'd13, 4'd15: n = 2;
            default:            n = 0;
         endcase
         case (pbv[3:0])
            4'd0:        off = 1;
            4'd1:        off = 2;
            4'd2:        off = -1;
            4'd3:        off = -2;
            4'd5:        off = int'($signed(bv));
            4'd6:        off = int'($signed(av));
            4'd8, 4'd12: off = int'($signed(mem[p1]));
            4'd9, 4'd13: off = int'(e16);
            4'd11:       off = int'({av, bv});
            default:     off = 0;
         endcase
         if (pbv[3:0] == 4'd15) e = e16;
         else                   e = 16'(int'(x) + off);
      end
      if (n >= 1) exp_rd.push_back(p1);
      if (n == 2) exp_rd.push_back(p2);
      if (ind) begin
         e1 = e + 16'd1;
         exp_rd.push_back(e);
         exp_rd.push_back(e1);
         e = {mem[e], mem[e1]};
      end
      exp_ea  = e;
      exp_pcn = 16'(int'(p) + 1 + n);
      exp_lat = 2 + n + (ind ? 2 : 0);
   endtask

   // cen_mode: 0 always on, 1 toggling, 2 random. wait_mode: 0 none, 1 random, 2 three stalls at read stall_idx
   task automatic run_txn(input logic [15:0] p, input logic [15:0] x,
                          input logic [7:0] av, input logic [7:0] bv,
                          input int cen_mode, input int wait_mode, input int stall_idx);
      int          busy_cyc, stalls, forced, nexp;
      logic        seen_done, prev_stall;
      logic [15:0] prev_addr;
      logic [7:0]  exp_pb;
      model_txn(p, x, av, bv);
      exp_pb = mem[p];
      @(negedge clk);
      pc = p; idx_reg = x; a = av; b = bv;
      start = 1'b1; cen = 1'b1; bus_wait = 1'b0;
      @(posedge clk); #1;
      check_val("busy_after_start", {31'd0, busy}, 32'd1);
      busy_cyc = 0; stalls = 0; forced = 0;
      seen_done = 1'b0; prev_stall = 1'b0; prev_addr = 16'h0;
      got_rd.delete();
      for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         pc    = 16'($urandom);
         case (cen_mode)
            0:       cen = 1'b1;
            1:       cen = ((cyc % 2) == 0);
            default: cen = ($urandom_range(0, 2) != 0);
         endcase
         case (wait_mode)
            0:       bus_wait = 1'b0;
            1:       bus_wait = ($urandom_range(0, 3) == 0);
            default: bus_wait = (got_rd.size() == stall_idx) && (forced < 3);
         endcase
         if (prev_stall) check_val("addr_hold_on_wait", {16'd0, bus_addr}, {16'd0, prev_addr});
         if (cen && busy) busy_cyc++;
         if (cen && bus_rd && !bus_wait) got_rd.push_back(bus_addr);
         if (cen && bus_rd && bus_wait) begin
            stalls++;
            forced++;
         end
         if (cen) prev_stall = bus_rd && bus_wait;
         prev_addr = bus_addr;
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      check_val("done_seen", {31'd0, seen_done}, 32'd1);
      check_val("ea", {16'd0, ea}, {16'd0, exp_ea});
      check_val("pc_nxt", {16'd0, pc_nxt}, {16'd0, exp_pcn});
      check_val("postbyte", {24'd0, postbyte}, {24'd0, exp_pb});
      check_val("latency", busy_cyc + 1, exp_lat + stalls);
      check_val("read_count", got_rd.size(), exp_rd.size());
      nexp = exp_rd.size();
      for (int i = 0; i < nexp && i < got_rd.size(); i++)
         check_val("read_addr", {16'd0, got_rd[i]}, {16'd0, exp_rd[i]});
      if (wait_mode == 2) check_val("stall_count", stalls, 3);
      @(negedge clk);
      start = 1'b0; cen = 1'b0; bus_wait = 1'b0;
      @(posedge clk); #1;
      check_val("done_hold_cen0", {31'd0, done}, 32'd1);
      @(negedge clk);
      cen = 1'b1;
      @(posedge clk); #1;
      check_val("done_pulse_end", {31'd0, done}, 32'd0);
      check_val("busy_end", {31'd0, busy}, 32'd0);
      check_val("ea_hold", {16'd0, ea}, {16'd0, exp_ea});
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      rstn = 1'b0; cen = 1'b0; start = 1'b0; bus_wait = 1'b0;
      pc = 16'h0; idx_reg = 16'h0; a = 8'h0; b = 8'h0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_bus_addr", {16'd0, bus_addr}, 32'd0);
      check_val("rst_postbyte", {24'd0, postbyte}, 32'd0);
      check_val("rst_ea", {16'd0, ea}, 32'd0);
      check_val("rst_pc_nxt", {16'd0, pc_nxt}, 32'd0);
      check_val("rst_flags", {29'd0, bus_rd, busy, done}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // 5-bit positive offset
      mem[16'h0100] = 8'h85;
      run_txn(16'h0100, 16'h2000, 8'h00, 8'h00, 0, 0, 0);
      check_val("ex_5bit_ea", {16'd0, ea}, 32'h2005);
      check_val("ex_5bit_pcn", {16'd0, pc_nxt}, 32'h0101);

      // 8-bit negative extension
      mem[16'h0100] = 8'h08; mem[16'h0101] = 8'hF0;
      run_txn(16'h0100, 16'h1000, 8'h00, 8'h00, 0, 0, 0);
      check_val("ex_off8_ea", {16'd0, ea}, 32'h0FF0);
      check_val("ex_off8_pcn", {16'd0, pc_nxt}, 32'h0102);

      // D-register offset
      mem[16'h0100] = 8'h0B;
      run_txn(16'h0100, 16'h0001, 8'h12, 8'h34, 0, 0, 0);
      check_val("ex_accd_ea", {16'd0, ea}, 32'h1235);

      // Extended indirect
      mem[16'h0100] = 8'h1F; mem[16'h0101] = 8'h12; mem[16'h0102] = 8'h34;
      mem[16'h1234] = 8'hAB; mem[16'h1235] = 8'hCD;
      run_txn(16'h0100, 16'h5555, 8'h00, 8'h00, 0, 0, 0);
      check_val("ex_extind_ea", {16'd0, ea}, 32'hABCD);
      check_val("ex_extind_pcn", {16'd0, pc_nxt}, 32'h0103);

      // Index wrap
      mem[16'h0100] = 8'h01;
      run_txn(16'h0100, 16'hFFFF, 8'h00, 8'h00, 0, 0, 0);
      check_val("ex_wrap_ea", {16'd0, ea}, 32'h0001);

      // Indirect pointer straddling FFFF -> 0000
      mem[16'h0100] = 8'h14; mem[16'hFFFF] = 8'h56; mem[16'h0000] = 8'h78;
      run_txn(16'h0100, 16'hFFFF, 8'h00, 8'h00, 0, 0, 0);
      check_val("ex_indwrap_ea", {16'd0, ea}, 32'h5678);

      // Three stalls on the EXT2 read with cen toggling
      mem[16'h0100] = 8'h09; mem[16'h0101] = 8'h01; mem[16'h0102] = 8'h10;
      run_txn(16'h0100, 16'h2000, 8'h00, 8'h00, 1, 2, 2);
      check_val("ex_stall_ea", {16'd0, ea}, 32'h2110);

      // Reset while in IND1, then a clean transaction
      mem[16'h0300] = 8'h14;
      @(negedge clk);
      pc = 16'h0300; idx_reg = 16'h4000; start = 1'b1; cen = 1'b1; bus_wait = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check_val("ind1_addr", {16'd0, bus_addr}, 32'h4000);
      check_val("ind1_rd", {31'd0, bus_rd}, 32'd1);
      rstn = 1'b0;
      #1;
      check_val("midrst_flags", {29'd0, bus_rd, busy, done}, 32'd0);
      check_val("midrst_ea", {16'd0, ea}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      run_txn(16'h0300, 16'h4000, 8'h00, 8'h00, 0, 0, 0);

      // Randomized postbytes, operands, cen and wait patterns
      for (int t = 0; t < 40; t++) begin
         logic [15:0] rp;
         rp = 16'($urandom);
         mem[rp] = 8'($urandom);
         run_txn(rp, 16'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 2), 1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
